// File: rtl/neuron_pkg.sv
// Shared state encoding and default widths for the neuron accumulator.
// NEURON_ACCUM_RELU_EN selects unsigned ReLU output instead of signed saturation.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ACT   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int N_CHUNKS = 49;
  localparam int SUM_W    = 20;
  localparam int ACC_W    = 26;
  localparam int BIAS_W   = 28;
  localparam int OUT_W    = 16;
  localparam int SHIFT    = 8;

endpackage

// File: rtl/neuron_act.sv
// Shift, activation and saturation of the biased neuron sum (purely combinational).
// NEURON_ACCUM_RELU_EN: negative -> 0, positive saturates unsigned; otherwise signed saturation.
module neuron_act #(
  parameter int ACC_W  = 26,
  parameter int BIAS_W = 28,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 16
) (
  input  logic signed [ACC_W+BIAS_W-1:0] sum,
  output logic        [OUT_W-1:0]        result
);

  localparam int SW = ACC_W + BIAS_W;

  logic signed [SW-1:0] shifted;

  assign shifted = sum >>> SHIFT;

`ifdef NEURON_ACCUM_RELU_EN
  localparam logic signed [SW-1:0] U_MAX = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  always_comb begin
    result = '0;
    if (shifted < 0)
      result = '0;
    else if (shifted > U_MAX)
      result = '1;
    else
      result = shifted[OUT_W-1:0];
  end
`else
  localparam logic signed [SW-1:0] S_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    result = '0;
    if (shifted > S_MAX)
      result = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < S_MIN)
      result = {1'b1, {(OUT_W-1){1'b0}}};
    else
      result = shifted[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/neuron_accum.sv
// Neuron evaluation sequencer: accumulates N_CHUNKS MAC sums, adds bias, activates, hands off.
// Output mode follows NEURON_ACCUM_RELU_EN (see neuron_act).
module neuron_accum
  import neuron_pkg::*;
#(
  parameter int N_CHUNKS = neuron_pkg::N_CHUNKS,
  parameter int SUM_W    = neuron_pkg::SUM_W,
  parameter int ACC_W    = neuron_pkg::ACC_W,
  parameter int BIAS_W   = neuron_pkg::BIAS_W,
  parameter int SHIFT    = neuron_pkg::SHIFT,
  parameter int OUT_W    = neuron_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     mac_valid,
  input  logic        [SUM_W-1:0]  mac_sum,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [OUT_W-1:0]  result
);

  localparam int CNT_W = $clog2(N_CHUNKS + 1);
  localparam int SW    = ACC_W + BIAS_W;

  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic signed [BIAS_W-1:0] bias_q;
  logic signed [SW-1:0]     sum_full;
  logic [OUT_W-1:0]         act_out;

  // acc is a non-negative magnitude that can exceed the signed ACC_W range, so zero-extend it
  assign sum_full = $signed({{BIAS_W{1'b0}}, acc})
                  + $signed({{ACC_W{bias_q[BIAS_W-1]}}, bias_q});

  neuron_act #(
    .ACC_W (ACC_W),
    .BIAS_W(BIAS_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_act (
    .sum   (sum_full),
    .result(act_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      bias_q    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= bias;
            busy   <= 1'b1;
            state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (mac_valid) begin
            acc <= acc + {{(ACC_W-SUM_W){1'b0}}, mac_sum};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(N_CHUNKS - 1))
              state <= ST_ACT;
          end
        end
        ST_ACT: begin
          result    <= act_out;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
